// File: rtl/regional_max_pkg.sv
// Shared types and constants for the regional-maxima engine.
// The neighbour offset table is centralised here so 4- and 8-connectivity share one source.
package regional_max_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SWEEP, CHECK, OUT} state_t;

    localparam int CONN_4 = 4;
    localparam int CONN_8 = 8;

    typedef logic [15:0] raster_idx_t;
    typedef logic [7:0]  row_t;
    typedef logic [7:0]  col_t;

    typedef struct packed {
        int dr;
        int dc;
    } nbr_off_t;

    // Entry k of the neighbour list; 8-connectivity walks the 3x3 window skipping the centre.
    function automatic nbr_off_t nbr_offset(input int conn, input int k);
        nbr_off_t o;
        int       w;
        o.dr = 0;
        o.dc = 0;
        if (conn == CONN_4) begin
            case (k)
                0:       begin o.dr = -1; o.dc = 0;  end
                1:       begin o.dr = 0;  o.dc = -1; end
                2:       begin o.dr = 0;  o.dc = 1;  end
                default: begin o.dr = 1;  o.dc = 0;  end
            endcase
        end else begin
            w    = (k < 4) ? k : k + 1;
            o.dr = w / 3 - 1;
            o.dc = w % 3 - 1;
        end
        return o;
    endfunction

endpackage

// File: rtl/regional_max_nbr_eval.sv
// Combinational clear decision for one pixel given its in-image neighbourhood.
module regional_max_nbr_eval
    import regional_max_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CONN        = CONN_8
) (
    input  logic [PIXEL_WIDTH-1:0]           centre,
    input  logic [CONN-1:0][PIXEL_WIDTH-1:0] nbr_val,
    input  logic [CONN-1:0]                  nbr_mask,
    input  logic [CONN-1:0]                  nbr_in,
    output logic                             clear
);

    logic [PIXEL_WIDTH-1:0] mx;
    logic                   eq_cleared;

    always_comb begin
        mx         = '0;
        eq_cleared = 1'b0;
        for (int k = 0; k < CONN; k++) begin
            if (nbr_in[k] && (nbr_val[k] > mx)) begin
                mx = nbr_val[k];
            end
            if (nbr_in[k] && (nbr_val[k] == centre) && !nbr_mask[k]) begin
                eq_cleared = 1'b1;
            end
        end
        clear = (mx > centre) || ((mx == centre) && eq_cleared);
    end

endmodule

// File: rtl/regional_max_engine.sv
// Streaming regional-maxima engine: load an image, sweep the mask in place until stable,
// then stream one flag per pixel in raster order.
module regional_max_engine
    import regional_max_pkg::*;
#(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int CONN        = 8,
    parameter int MAX_ITER    = 64,
    parameter int ITER_WIDTH  = $clog2(MAX_ITER + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_flag,
    output logic                   out_last,
    output logic                   busy,
    output logic [ITER_WIDTH-1:0]  iter_count,
    output logic                   iter_overflow
);

    localparam int NPIX = M * N;
    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_CAP = ITER_WIDTH'(MAX_ITER);

    if (CONN != CONN_4 && CONN != CONN_8) begin : g_bad_conn
        $error("regional_max_engine: CONN must be 4 or 8");
    end

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg;
    row_t                    row_reg;
    col_t                    col_reg;
    logic [NPIX-1:0]         mask_reg;
    logic                    changed_reg;
    logic [ITER_WIDTH-1:0]   iter_reg;
    logic                    ovf_reg;
    logic                    run_reg;
    logic [PIXEL_WIDTH-1:0]  img [NPIX];

    logic                             accept, out_fire, clear;
    logic [CONN-1:0][PIXEL_WIDTH-1:0] nbr_val;
    logic [CONN-1:0]                  nbr_mask, nbr_in;

    assign accept   = pix_valid && pix_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            img[(state_reg == IDLE) ? '0 : idx_reg] <= pix_data;
        end
    end

    // Out-of-image neighbours read as value 0 with mask 1, so they never trigger a clear.
    for (genvar gi = 0; gi < CONN; gi++) begin : g_nbr
        localparam nbr_off_t OFF = nbr_offset(CONN, gi);
        int               nr, nc;
        logic             inb;
        logic [IDX_W-1:0] lin;
        always_comb begin
            nr  = int'(row_reg) + OFF.dr;
            nc  = int'(col_reg) + OFF.dc;
            inb = (nr >= 0) && (nr < M) && (nc >= 0) && (nc < N);
            lin = inb ? IDX_W'(nr * N + nc) : idx_reg;
        end
        assign nbr_in[gi]   = inb;
        assign nbr_val[gi]  = inb ? img[lin] : '0;
        assign nbr_mask[gi] = inb ? mask_reg[lin] : 1'b1;
    end

    regional_max_nbr_eval #(.PIXEL_WIDTH(PIXEL_WIDTH), .CONN(CONN)) u_eval (
        .centre  (img[idx_reg]),
        .nbr_val (nbr_val),
        .nbr_mask(nbr_mask),
        .nbr_in  (nbr_in),
        .clear   (clear)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = LOAD;
            LOAD:  if (accept && idx_reg == LAST_IDX) state_next = SWEEP;
            SWEEP: if (idx_reg == LAST_IDX) state_next = CHECK;
            CHECK: state_next = (changed_reg && iter_reg != ITER_CAP) ? SWEEP : OUT;
            OUT:   if (out_fire && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pix_ready     = run_reg && (state_reg == IDLE || state_reg == LOAD);
        out_valid     = (state_reg == OUT);
        out_flag      = (state_reg == OUT) ? mask_reg[idx_reg] : 1'b0;
        out_last      = (state_reg == OUT) && (idx_reg == LAST_IDX);
        busy          = (state_reg != IDLE);
        iter_count    = iter_reg;
        iter_overflow = ovf_reg;
    end

    // run_reg holds pix_ready low for the cycle following reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_reg     <= 1'b0;
            idx_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            mask_reg    <= '0;
            changed_reg <= 1'b0;
            iter_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            case (state_reg)
                IDLE: if (accept) begin
                    idx_reg  <= IDX_W'(1);
                    iter_reg <= '0;
                    ovf_reg  <= 1'b0;
                end
                LOAD: if (accept) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_reg     <= '0;
                        row_reg     <= '0;
                        col_reg     <= '0;
                        mask_reg    <= '1;
                        changed_reg <= 1'b0;
                        iter_reg    <= '0;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                SWEEP: begin
                    if (mask_reg[idx_reg] && clear) begin
                        mask_reg[idx_reg] <= 1'b0;
                        changed_reg       <= 1'b1;
                    end
                    if (idx_reg == LAST_IDX) begin
                        iter_reg <= iter_reg + ITER_WIDTH'(1);
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                        if (col_reg == col_t'(N - 1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + row_t'(1);
                        end else begin
                            col_reg <= col_reg + col_t'(1);
                        end
                    end
                end
                CHECK: begin
                    idx_reg <= '0;
                    row_reg <= '0;
                    col_reg <= '0;
                    if (changed_reg && iter_reg == ITER_CAP) ovf_reg <= 1'b1;
                    else if (changed_reg)                    changed_reg <= 1'b0;
                end
                OUT: if (out_fire) begin
                    idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regional_max_engine.sv
// Directed bench: three 4x4 engines (CONN=8, CONN=4, CONN=8 with a one-sweep cap).
module tb_regional_max_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       pv [3];
    logic [7:0] pd [3];
    logic       ordy [3];
    logic       pr [3], ov [3], of [3], ol [3], bz [3], io [3];
    logic [6:0] ic8, ic4;
    logic [0:0] ic1;

    regional_max_engine #(.M(4), .N(4), .PIXEL_WIDTH(8), .CONN(8), .MAX_ITER(64)) u8 (
        .clk(clk), .reset_n(reset_n), .pix_valid(pv[0]), .pix_ready(pr[0]), .pix_data(pd[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_flag(of[0]), .out_last(ol[0]),
        .busy(bz[0]), .iter_count(ic8), .iter_overflow(io[0]));

    regional_max_engine #(.M(4), .N(4), .PIXEL_WIDTH(8), .CONN(4), .MAX_ITER(64)) u4 (
        .clk(clk), .reset_n(reset_n), .pix_valid(pv[1]), .pix_ready(pr[1]), .pix_data(pd[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_flag(of[1]), .out_last(ol[1]),
        .busy(bz[1]), .iter_count(ic4), .iter_overflow(io[1]));

    regional_max_engine #(.M(4), .N(4), .PIXEL_WIDTH(8), .CONN(8), .MAX_ITER(1)) u1 (
        .clk(clk), .reset_n(reset_n), .pix_valid(pv[2]), .pix_ready(pr[2]), .pix_data(pd[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_flag(of[2]), .out_last(ol[2]),
        .busy(bz[2]), .iter_count(ic1), .iter_overflow(io[2]));

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] tb_img [16];

    function automatic logic [6:0] get_ic(input int sel);
        if (sel == 0) return ic8;
        if (sel == 1) return ic4;
        return {6'b0, ic1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) tb_img[i] = v;
    endtask

    task automatic load_img(input int sel);
        for (int i = 0; i < 16; i++) begin
            int n = 0;
            pv[sel] = 1'b1;
            pd[sel] = tb_img[i];
            while (!pr[sel] && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("load_ready", {31'b0, pr[sel]}, 32'd1);
            if (!pr[sel]) break;
            @(negedge clk);
        end
        pv[sel] = 1'b0;
    endtask

    // Collects 16 flags, optionally alternating out_ready; checks hold-stability on stalls.
    task automatic run_case(input string tag, input int sel, input bit bp, input logic [15:0] exp_flags);
        logic [15:0] flags = '0;
        int beats = 0, last_beat = -1, stall_bad = 0, cyc = 0;
        bit tog = 1'b1, have_prev = 1'b0;
        logic pf = 1'b0, pl = 1'b0;
        load_img(sel);
        while (beats < 16 && cyc < 3000) begin
            ordy[sel] = bp ? tog : 1'b1;
            tog = !tog;
            if (have_prev && (of[sel] !== pf || ol[sel] !== pl)) stall_bad++;
            have_prev = 1'b0;
            if (ov[sel]) begin
                if (ordy[sel]) begin
                    flags[beats] = of[sel];
                    if (ol[sel]) last_beat = (last_beat < 0) ? beats : 99;
                    beats++;
                end else begin
                    have_prev = 1'b1;
                    pf = of[sel];
                    pl = ol[sel];
                end
            end
            @(negedge clk);
            cyc++;
        end
        ordy[sel] = 1'b0;
        $display("%s: sel=%0d flags=%04h beats=%0d last_beat=%0d iters=%0d ovf=%0b",
                 tag, sel, flags, beats, last_beat, get_ic(sel), io[sel]);
        chk({tag, "_flags"}, {16'b0, flags}, {16'b0, exp_flags});
        chk({tag, "_beats"}, beats, 16);
        chk({tag, "_last_beat"}, last_beat, 15);
        chk({tag, "_stall_stable"}, stall_bad, 0);
        chk({tag, "_valid_after"}, {31'b0, ov[sel]}, 32'd0);
        chk({tag, "_busy_after"}, {31'b0, bz[sel]}, 32'd0);
    endtask

    task automatic chk_zero(input string tag, input int sel);
        chk({tag, "_pix_ready"}, {31'b0, pr[sel]}, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, ov[sel]}, 32'd0);
        chk({tag, "_out_flag"}, {31'b0, of[sel]}, 32'd0);
        chk({tag, "_out_last"}, {31'b0, ol[sel]}, 32'd0);
        chk({tag, "_busy"}, {31'b0, bz[sel]}, 32'd0);
        chk({tag, "_iter_count"}, {25'b0, get_ic(sel)}, 32'd0);
        chk({tag, "_iter_overflow"}, {31'b0, io[sel]}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pv[s] = 1'b0;
            pd[s] = '0;
            ordy[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) chk_zero("reset", s);
        reset_n = 1'b1;
        @(negedge clk);

        // Single peak at (1,2)
        fill(8'd10); tb_img[6] = 8'd50;
        run_case("peak", 0, 1'b0, 16'h0040);
        chk("peak_overflow", {31'b0, io[0]}, 32'd0);

        // Flat image converges in one sweep
        fill(8'd7);
        run_case("flat", 0, 1'b0, 16'hFFFF);
        chk("flat_iter_count", {25'b0, ic8}, 32'd1);
        chk("flat_overflow", {31'b0, io[0]}, 32'd0);

        // Diagonal pair under both connectivities
        fill(8'd1); tb_img[0] = 8'd5; tb_img[5] = 8'd6;
        run_case("diag_c8", 0, 1'b0, 16'h0020);
        run_case("diag_c4", 1, 1'b0, 16'h0021);

        // Two-pixel plateau
        fill(8'd3); tb_img[5] = 8'd9; tb_img[6] = 8'd9;
        run_case("plateau", 0, 1'b0, 16'h0060);

        // Output backpressure on the single-peak image
        fill(8'd10); tb_img[6] = 8'd50;
        run_case("backpressure", 0, 1'b1, 16'h0040);

        // One-sweep cap on a ramp: only the bottom-right survives the first sweep
        for (int i = 0; i < 16; i++) tb_img[i] = 8'(i);
        run_case("cap", 2, 1'b0, 16'h8000);
        chk("cap_overflow", {31'b0, io[2]}, 32'd1);
        chk("cap_iter_count", {25'b0, get_ic(2)}, 32'd1);

        // Reset mid-sweep, then a clean rerun
        fill(8'd10); tb_img[6] = 8'd50;
        load_img(0);
        repeat (2) @(negedge clk);
        chk("midsweep_busy", {31'b0, bz[0]}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_zero("midreset", 0);
        @(negedge clk);
        chk("midreset_ready_back", {31'b0, pr[0]}, 32'd1);
        fill(8'd3); tb_img[5] = 8'd9; tb_img[6] = 8'd9;
        run_case("after_reset", 0, 1'b0, 16'h0060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
